// File: rtl/cga_vram_arbiter.sv
// cga_vram_arbiter: shares CGA VRAM between the video sequencer (always first) and ISA CPU accesses
module cga_vram_arbiter #(
    parameter int USE_BUS_WAIT  = 1,
    parameter int CPU_ADDR_BITS = 15
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic [14:0] bus_a,
    input  logic [7:0]  bus_d,
    input  logic        bus_memr_l,
    input  logic        bus_memw_l,
    input  logic        mem_cs,
    input  logic        video_slot,
    input  logic [18:0] vid_a,
    input  logic [7:0]  ram_d,
    output logic [18:0] ram_a,
    output logic        ram_we_l,
    output logic [7:0]  ram_dout,
    output logic [7:0]  bus_out,
    output logic        bus_dir,
    output logic        bus_rdy
);
    typedef enum logic [2:0] {IDLE, WAIT_SLOT, ACCESS, CAPTURE, DONE} state_t;
    localparam logic [14:0] AMASK = 15'((32'd1 << CPU_ADDR_BITS) - 32'd1);
    state_t      state, next;
    logic [1:0]  memr_sync, memw_sync, hold;
    logic        memr, memw, memr_prev, memw_prev, armed, wr_q;
    logic        rd_fall, wr_fall, start, strobe_off, acc;
    logic [14:0] a_q;
    logic [7:0]  d_q;
    assign memr = memr_sync[1];
    assign memw = memw_sync[1];
    // armed only once the synced strobes are seen high after reset, so a strobe held low through reset is ignored
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state     <= IDLE;
            memr_sync <= 2'b11;
            memw_sync <= 2'b11;
            memr_prev <= 1'b1;
            memw_prev <= 1'b1;
            hold      <= 2'd0;
            armed     <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
            wr_q      <= 1'b0;
            bus_out   <= '0;
        end else begin
            state     <= next;
            memr_sync <= {memr_sync[0], bus_memr_l};
            memw_sync <= {memw_sync[0], bus_memw_l};
            memr_prev <= memr;
            memw_prev <= memw;
            hold      <= hold + 2'(hold != 2'd2);
            armed     <= armed | (hold == 2'd2 && memr && memw);
            if (start) begin
                a_q  <= bus_a;
                d_q  <= bus_d;
                wr_q <= wr_fall;
            end
            if (state == CAPTURE) bus_out <= ram_d;
        end
    end
    always_comb begin
        rd_fall    = memr_prev & ~memr;
        wr_fall    = memw_prev & ~memw;
        start      = state == IDLE && armed && mem_cs && (rd_fall || wr_fall);
        strobe_off = wr_q ? memw : memr;
        acc        = state == ACCESS && !video_slot;
        next       = state;
        case (state)
            IDLE:      next = start ? WAIT_SLOT : IDLE;
            WAIT_SLOT: next = video_slot ? WAIT_SLOT : ACCESS;
            ACCESS:    next = video_slot ? WAIT_SLOT : (wr_q ? DONE : CAPTURE);
            CAPTURE:   next = DONE;
            DONE:      next = strobe_off ? IDLE : DONE;
            default:   next = IDLE;
        endcase
        ram_a    = acc ? {4'b0, a_q & AMASK} : vid_a;
        ram_we_l = ~(acc && wr_q && reset_l);
        ram_dout = d_q;
        bus_dir  = state == DONE && !wr_q && !memr;
        bus_rdy  = USE_BUS_WAIT == 0 || !(state inside {WAIT_SLOT, ACCESS, CAPTURE});
    end
endmodule

// File: tb/tb_cga_vram_arbiter.sv
// tb_cga_vram_arbiter: directed ISA accesses against a wait-state build and a no-wait build, scoreboarded
module tb_cga_vram_arbiter;
    logic        clk = 0, reset_l = 0, bus_memr_l = 1, bus_memw_l = 1, mem_cs = 0, video_slot = 0;
    logic [14:0] bus_a = '0;
    logic [7:0]  bus_d = '0, ram_d = '0, rd_data = '0;
    logic [18:0] vid_a = 19'h5A5A5, rd_addr = '0;
    logic [18:0] ram_a, ram_a0;
    logic        ram_we_l, ram_we_l0, bus_dir, bus_dir0, bus_rdy, bus_rdy0, dir_prev = 0;
    logic [7:0]  ram_dout, ram_dout0, bus_out, bus_out0;
    logic [26:0] wq[$], wq0[$];
    logic [7:0]  rq[$];
    int n_checks = 0, n_fail = 0;

    cga_vram_arbiter dut (.clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_d(bus_d),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .mem_cs(mem_cs), .video_slot(video_slot),
        .vid_a(vid_a), .ram_d(ram_d), .ram_a(ram_a), .ram_we_l(ram_we_l), .ram_dout(ram_dout),
        .bus_out(bus_out), .bus_dir(bus_dir), .bus_rdy(bus_rdy));
    cga_vram_arbiter #(.USE_BUS_WAIT(0)) dut0 (.clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_d(bus_d),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l), .mem_cs(mem_cs), .video_slot(video_slot),
        .vid_a(vid_a), .ram_d(ram_d), .ram_a(ram_a0), .ram_we_l(ram_we_l0), .ram_dout(ram_dout0),
        .bus_out(bus_out0), .bus_dir(bus_dir0), .bus_rdy(bus_rdy0));

    always #5 clk = ~clk;
    // VRAM returns the programmed byte one clock after its address appears, filler otherwise
    always @(posedge clk) ram_d <= (ram_a == rd_addr) ? rd_data : 8'hEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [26:0] e;
        if (ram_we_l === 1'b0) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = wq.pop_front();
                chk("write_addr", 32'(ram_a), 32'(e[26:8]));
                chk("write_data", 32'(ram_dout), 32'(e[7:0]));
            end
        end
        if (ram_we_l0 === 1'b0) begin
            if (wq0.size() == 0) chk("nowait_unexpected_write", 1, 0);
            else begin
                e = wq0.pop_front();
                chk("nowait_write_addr", 32'(ram_a0), 32'(e[26:8]));
                chk("nowait_write_data", 32'(ram_dout0), 32'(e[7:0]));
            end
        end
        if (bus_dir === 1'b1 && dir_prev !== 1'b1) begin
            if (rq.size() == 0) chk("unexpected_read", 1, 0);
            else chk("read_data", 32'(bus_out), 32'(rq.pop_front()));
        end
        dir_prev = bus_dir;
        chk("nowait_rdy", 32'(bus_rdy0), 1);
    end

    // mode 0: free VRAM, 1: sequencer holds VRAM 6 cycles, 2: sequencer steals the ACCESS cycle
    task automatic access(input bit w, input bit r, input logic [14:0] a, input logic [7:0] d, input int mode);
        int k;
        @(posedge clk); #1;
        if (w) begin
            wq.push_back({4'b0, a, d});
            wq0.push_back({4'b0, a, d});
        end else begin
            rq.push_back(d);
            rd_addr = {4'b0, a};
            rd_data = d;
        end
        bus_a = a;
        bus_d = w ? d : 8'h77;
        mem_cs = 1;
        video_slot = (mode == 1);
        bus_memw_l = ~w;
        bus_memr_l = ~r;
        for (k = 0; k < 10 && bus_rdy !== 1'b0; k++) @(negedge clk);
        chk("rdy_low", 32'(bus_rdy), 0);
        if (mode == 1) begin
            repeat (6) begin
                @(negedge clk);
                chk("slot_ram_a", 32'(ram_a), 32'(vid_a));
                chk("slot_rdy", 32'(bus_rdy), 0);
            end
            @(posedge clk); #1 video_slot = 0;
        end
        if (mode == 2) begin
            @(posedge clk); #1 video_slot = 1;
            @(negedge clk);
            chk("abort_we", 32'(ram_we_l), 1);
            chk("abort_ram_a", 32'(ram_a), 32'(vid_a));
            repeat (2) @(posedge clk);
            #1 video_slot = 0;
        end
        for (k = 0; k < 40 && bus_rdy !== 1'b1; k++) @(negedge clk);
        chk("rdy_high", 32'(bus_rdy), 1);
        chk("dir_done", 32'(bus_dir), (r && !w) ? 1 : 0);
        @(posedge clk); #1;
        bus_memw_l = 1;
        bus_memr_l = 1;
        repeat (4) @(negedge clk);
        chk("dir_release", 32'(bus_dir), 0);
        chk("rdy_idle", 32'(bus_rdy), 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(bus_rdy), 1);
        chk("rst_we", 32'(ram_we_l), 1);
        chk("rst_dir", 32'(bus_dir), 0);
        chk("rst_bus_out", 32'(bus_out), 0);
        chk("rst_ram_dout", 32'(ram_dout), 0);
        chk("rst_ram_a", 32'(ram_a), 32'(vid_a));
        @(posedge clk); #1 reset_l = 1;
        repeat (5) @(posedge clk);
        access(1, 0, 15'h0123, 8'hA5, 0);
        access(0, 1, 15'h7FFF, 8'h3C, 1);
        access(0, 1, 15'h0001, 8'hC3, 0);
        access(1, 0, 15'h2AAA, 8'h81, 2);
        access(1, 1, 15'h1357, 8'h6E, 0);
        // strobe outside the framebuffer window
        @(posedge clk); #1;
        mem_cs = 0;
        bus_a = 15'h0200;
        bus_memw_l = 0;
        repeat (8) begin
            @(negedge clk);
            chk("nocs_rdy", 32'(bus_rdy), 1);
            chk("nocs_we", 32'(ram_we_l), 1);
        end
        @(posedge clk); #1 bus_memw_l = 1;
        repeat (4) @(posedge clk);
        // reset while waiting for the sequencer, strobe kept low across it
        #1;
        video_slot = 1;
        mem_cs = 1;
        bus_a = 15'h0300;
        bus_d = 8'h99;
        bus_memw_l = 0;
        for (int k = 0; k < 10 && bus_rdy !== 1'b0; k++) @(negedge clk);
        chk("rst_wait_rdy_low", 32'(bus_rdy), 0);
        reset_l = 0;
        @(negedge clk);
        chk("rstw_rdy", 32'(bus_rdy), 1);
        chk("rstw_we", 32'(ram_we_l), 1);
        chk("rstw_dir", 32'(bus_dir), 0);
        @(posedge clk); #1;
        reset_l = 1;
        video_slot = 0;
        repeat (12) begin
            @(negedge clk);
            chk("held_strobe_rdy", 32'(bus_rdy), 1);
        end
        @(posedge clk); #1 bus_memw_l = 1;
        repeat (5) @(posedge clk);
        access(1, 0, 15'h0456, 8'h5A, 0);
        repeat (4) @(negedge clk);
        chk("writes_left", wq.size(), 0);
        chk("nowait_writes_left", wq0.size(), 0);
        chk("reads_left", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cga_vram_arbiter.md
CGA_VRAM_ARBITER -- requirements
Module: cga_vram_arbiter

Interface
REQ-001 SHALL have parameter USE_BUS_WAIT, default 1: 1 = drive bus_rdy wait states; 0 = bus_rdy tied 1, with accesses still performed.
REQ-002 SHALL have parameter CPU_ADDR_BITS, default 15: number of bus_a bits forwarded to ram_a; upper ram_a bits are 0.
REQ-003 SHALL have port clk, input, 1: single system clock; all logic rises on posedge clk.
REQ-004 SHALL have port reset_l, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port bus_a, input, 15: ISA memory address within the framebuffer window.
REQ-006 SHALL have port bus_d, input, 8: ISA write data.
REQ-007 SHALL have ports bus_memr_l and bus_memw_l, input, 1 each: ISA memory strobes, asynchronous, active-low.
REQ-008 SHALL have port mem_cs, input, 1: framebuffer window decode, combinational, from the parent.
REQ-009 SHALL have port video_slot, input, 1: when 1, the sequencer owns the VRAM this cycle.
REQ-010 SHALL have port vid_a, input, 19: sequencer/CRTC fetch address.
REQ-011 SHALL have port ram_d, input, 8: VRAM read data, valid one clk after ram_a.
REQ-012 SHALL have port ram_a, output, 19: muxed VRAM address.
REQ-013 SHALL have port ram_we_l, output, 1: VRAM write strobe, active-low.
REQ-014 SHALL have port ram_dout, output, 8: VRAM write data.
REQ-015 SHALL have port bus_out, output, 8: CPU read data.
REQ-016 SHALL have port bus_dir, output, 1: 1 while bus_out drives a CPU read.
REQ-017 SHALL have port bus_rdy, output, 1: ISA ready, 0 = insert wait state.

Function
REQ-018 SHALL resynchronise bus_memr_l and bus_memw_l through two flops each; all decisions SHALL use the synced copies.
REQ-019 SHALL implement the FSM states IDLE, WAIT_SLOT, ACCESS, CAPTURE, DONE.
REQ-020 In IDLE, a synced strobe going high-to-low with mem_cs=1 SHALL latch bus_a, bus_d and the direction (write if memw, else read), and SHALL move to WAIT_SLOT.
REQ-021 If memr and memw fall in the same cycle, the write SHALL win.
REQ-022 In WAIT_SLOT, video_slot=0 SHALL move the FSM to ACCESS on the next edge; video_slot=1 SHALL hold the FSM in WAIT_SLOT.
REQ-023 The sequencer SHALL always have priority: in any cycle with video_slot=1, ram_a=vid_a and ram_we_l=1.
REQ-024 In ACCESS, ram_a SHALL be {zeros, latched bus_a}; for a write, ram_we_l=0 and ram_dout=latched bus_d for exactly one cycle, then DONE; for a read, the next state SHALL be CAPTURE.
REQ-025 If video_slot=1 during ACCESS, the access SHALL abort with no write pulse and the FSM SHALL return to WAIT_SLOT.
REQ-026 In CAPTURE, ram_d SHALL be registered into bus_out, then DONE; CPU read latency SHALL be at least 3 clk after WAIT_SLOT exits.
REQ-027 With USE_BUS_WAIT=1, bus_rdy SHALL be 0 from the cycle after request latch until entry to DONE, and 1 otherwise.
REQ-028 DONE SHALL hold bus_out and bus_dir (read) until the synced strobe deasserts, then return to IDLE; one strobe SHALL produce exactly one access.
REQ-029 bus_dir SHALL be 1 only in DONE for a read with the synced memr still 0.
REQ-030 When not in ACCESS, ram_a SHALL equal vid_a.
REQ-031 A strobe with mem_cs=0 SHALL be ignored, with bus_rdy=1 and no RAM activity.

Reset
REQ-032 reset_l=0 at a clk edge SHALL force IDLE, bus_rdy=1, ram_we_l=1, bus_dir=0, bus_out=8'h00 and ram_dout=8'h00, and SHALL clear the sync flops to 1.
REQ-033 Reset mid-ACCESS SHALL cancel the write, with ram_we_l high on the same edge.
REQ-034 After reset release, a strobe already low SHALL NOT start an access until it goes high and falls again.

Verification
REQ-035 Write 8'hA5 to bus_a=15'h0123 with video_slot=0 -> one-cycle ram_we_l=0 with ram_a=19'h00123 and ram_dout=8'hA5; bus_rdy low then high.
REQ-036 Read 15'h7FFF with ram_d=8'h3C and video_slot=1 for 6 cycles -> bus_rdy stays 0 through the slot; then bus_out=8'h3C, bus_dir=1, bus_rdy=1.
REQ-037 video_slot rises during ACCESS -> no write pulse, FSM retries, exactly one write occurs later.
REQ-038 memr and memw fall together -> a write is performed and bus_dir stays 0.
REQ-039 reset_l=0 during WAIT_SLOT -> next edge bus_rdy=1, ram_we_l=1, FSM IDLE; a held strobe is ignored until re-asserted.
REQ-040 USE_BUS_WAIT=0 build -> bus_rdy constant 1 while the write of REQ-035 still lands.
